// File: rtl/sevseg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package sevseg_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_e;

  localparam int NUM_DIGITS = 8;

  // Segment patterns are active-low, bit6=a .. bit0=g.
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Hex glyphs; entry 15 first because this is a packed concatenation.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage

// File: rtl/sevseg_slot_timer.sv
// Slot counter and digit index for the scan controller. A slot is
// CLK_DIV cycles; eight slots make one frame.
module sevseg_slot_timer
  import sevseg_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  output logic [CW-1:0] o_slot_cnt,
  output logic [2:0]    o_digit_idx,
  output logic          o_slot_wrap,
  output logic          o_frame_wrap
);

  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;

  assign o_slot_cnt   = r_cnt;
  assign o_digit_idx  = r_idx;
  assign o_slot_wrap  = (r_cnt == CW'(CLK_DIV - 1));
  assign o_frame_wrap = o_slot_wrap && (r_idx == 3'(NUM_DIGITS - 1));

  // Count cycles within a slot; the digit index wraps 7 -> 0 on its own.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (o_slot_wrap) begin
      r_cnt <= '0;
      r_idx <= r_idx + 3'd1;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sevseg_scan_ctrl.sv
// 8-digit seven-segment scan controller. Snapshots one of two 32-bit
// counters per frame and scans it out with a blank gap before each digit.
// Optional macro SEVSEG_AUTOCYCLE_EN: alternate sources every AUTO_FRAMES
// frames instead of following i_sel, and mark src1 with the digit-7 dp.
module sevseg_scan_ctrl
  import sevseg_pkg::*;
#(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 64
`ifdef SEVSEG_AUTOCYCLE_EN
  ,
  parameter int AUTO_FRAMES  = 512
`endif
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_src0,
  input  logic [31:0] i_src1,
  input  logic        i_sel,
  input  logic        i_freeze,
  input  logic        i_lz_blank,
  output logic [7:0]  o_an,
  output logic [6:0]  o_seg,
  output logic        o_dp,
  output logic        o_frame_start,
  output logic        o_cur_src
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] w_slot_cnt;
  logic [2:0]    w_idx;
  logic          w_slot_wrap;
  logic          w_frame_wrap;

  state_e        r_state, w_state_nxt;
  logic [31:0]   r_snap;
  logic          r_src;
  logic          w_src_nxt;
  logic [NUM_DIGITS-1:0] w_lz;
  logic [3:0]    w_nib;

  logic [7:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic          r_frame_start;

  sevseg_slot_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .o_slot_cnt   (w_slot_cnt),
    .o_digit_idx  (w_idx),
    .o_slot_wrap  (w_slot_wrap),
    .o_frame_wrap (w_frame_wrap)
  );

  // State register; reset lands in LOAD so a frame starts right after release.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= LOAD;
    else       r_state <= w_state_nxt;
  end

  // LOAD lasts one cycle at slot 0 of digit 0; each slot is BLANK then SHOW.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      LOAD:    w_state_nxt = BLANK;
      BLANK:   if (int'(w_slot_cnt) >= BLANK_CYCLES - 1) w_state_nxt = SHOW;
      SHOW: begin
        if (w_frame_wrap)     w_state_nxt = LOAD;
        else if (w_slot_wrap) w_state_nxt = BLANK;
      end
      default: w_state_nxt = LOAD;
    endcase
  end

`ifdef SEVSEG_AUTOCYCLE_EN
  logic [15:0] r_frame_cnt;
  logic        w_auto_toggle;

  assign w_auto_toggle = (r_frame_cnt == 16'(AUTO_FRAMES - 1));
  assign w_src_nxt     = w_auto_toggle ? ~r_src : r_src;

  // Frames-per-source counter, advanced only by unfrozen LOADs.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_frame_cnt <= '0;
    else if (r_state == LOAD && !i_freeze)
      r_frame_cnt <= w_auto_toggle ? 16'd0 : r_frame_cnt + 16'd1;
  end
`else
  // i_sel=1 picks src0, so the displayed source index is its inverse.
  assign w_src_nxt = ~i_sel;
`endif

  // Atomic per-frame snapshot; freeze keeps both value and source.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_snap <= '0;
      r_src  <= 1'b0;
    end else if (r_state == LOAD && !i_freeze) begin
      r_src  <= w_src_nxt;
      r_snap <= w_src_nxt ? i_src1 : i_src0;
    end
  end

  // Leading-zero flags: digit d blanks when nibbles d..7 are all zero.
  always_comb begin
    w_lz = '0;
    for (int d = 1; d < NUM_DIGITS; d++)
      w_lz[d] = i_lz_blank && ((r_snap >> (4 * d)) == 32'd0);
  end

  assign w_nib = r_snap[{w_idx, 2'b00} +: 4];

  // Registered pin drive; everything is dark outside SHOW.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_an          <= AN_OFF;
      r_seg         <= SEG_OFF;
      r_dp          <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= (r_state == LOAD);
      r_an          <= AN_OFF;
      r_seg         <= SEG_OFF;
      r_dp          <= 1'b1;
      if (r_state == SHOW) begin
        r_an  <= ~(8'b1 << w_idx);
        r_seg <= w_lz[w_idx] ? SEG_OFF : hex_decode(w_nib);
`ifdef SEVSEG_AUTOCYCLE_EN
        r_dp  <= ~((w_idx == 3'(NUM_DIGITS - 1)) && r_src);
`endif
      end
    end
  end

  assign o_an          = r_an;
  assign o_seg         = r_seg;
  assign o_dp          = r_dp;
  assign o_frame_start = r_frame_start;
  assign o_cur_src     = r_src;

endmodule

// File: doc/sevseg_scan_ctrl.md
Name: sevseg_scan_ctrl

Overview:
- Time-multiplexed 8-digit seven-segment scan controller for the Nexys A7 top level.
- Shares the single display between two 32-bit performance counters: branches and branches-taken.
- Takes an atomic per-frame snapshot of the selected source and sequences the anodes with an anti-ghosting blank interval.
- Drives the board-level an/ca..cg/dp pins. Runs on clk_core.

Parameters:
- CLK_DIV, 50000: clock cycles per digit slot; must be greater than BLANK_CYCLES+1.
- BLANK_CYCLES, 64: cycles at the start of each slot with all anodes off.
- AUTO_FRAMES, 512: frames per source when SEVSEG_AUTOCYCLE_EN is defined.

Ports:
- i_clk, in, 1: clock.
- i_rst, in, 1: reset, synchronous, active-high.
- i_src0, in, 32: source 0 (branches_counter).
- i_src1, in, 32: source 1 (branches_taken_counter).
- i_sel, in, 1: source select, already synchronised; 1 selects src0.
- i_freeze, in, 1: hold the current snapshot.
- i_lz_blank, in, 1: enable leading-zero blanking.
- o_an, out, 8: anodes, active-low; bit n is digit n.
- o_seg, out, 7: segments, active-low; bit6=a … bit0=g.
- o_dp, out, 1: decimal point, active-low.
- o_frame_start, out, 1: one-cycle pulse in the LOAD cycle.
- o_cur_src, out, 1: source currently displayed (0=src0, 1=src1).

Behaviour:
- Reset values:
  - o_an=8'hFF, o_seg=7'h7F, o_dp=1, o_frame_start=0, o_cur_src=0.
  - snapshot=0, digit index=0, slot counter=0, state=LOAD.
- Slot counter:
  - Counts 0..CLK_DIV-1, then wraps to 0.
  - On wrap, the digit index advances 0→7; from 7 it returns to 0 and the FSM enters LOAD.
- FSM states:
  - LOAD: exactly one cycle at slot count 0 of digit 0. Captures the snapshot from the selected source unless i_freeze=1. Latches the source. Pulses o_frame_start. Goes to BLANK.
  - BLANK: while slot count < BLANK_CYCLES, o_an=FF and o_seg=7F. Goes to SHOW when the count reaches BLANK_CYCLES.
  - SHOW: drives the anode for the digit index low and o_seg=decode(snapshot[4*idx+3:4*idx]). On slot wrap, goes to BLANK (next digit) or LOAD (after digit 7).
- Latency: all outputs are registered, one cycle after the state/counter that produces them.
- Source select, normal build: the source is taken from i_sel only in LOAD. i_sel=1 selects src0, matching the existing switch semantics; o_cur_src=~i_sel. A mid-frame change of i_sel takes effect at the next frame.
- Decode table, hex 0..F:
  - 0:0000001, 1:1001111, 2:0010010, 3:0000110
  - 4:1001100, 5:0100100, 6:0100000, 7:0001111
  - 8:0000000, 9:0000100, A:0001000, b:1100000
  - C:0110001, d:1000010, E:0110000, F:0111000
- Leading-zero blanking:
  - Digit d>0 is blanked (o_seg=7F, anode still asserted) when i_lz_blank=1 and nibbles d..7 are all zero.
  - Digit 0 is never blanked.
  - The flags are computed from the snapshot, so they are stable for the whole frame.
- Freeze: while i_freeze=1, LOAD keeps both the snapshot and the source. The scan continues.
- Reset mid-frame: in the next cycle all state returns to reset values, and the first LOAD follows immediately after reset is released.
- Exactly one anode is low at any time outside BLANK; none is low during BLANK or LOAD.

Optional Feature:
- Macro: SEVSEG_AUTOCYCLE_EN.
- Defined:
  - i_sel is ignored.
  - A 16-bit frame counter toggles the source every AUTO_FRAMES frames, evaluated in LOAD and suppressed while i_freeze=1.
  - o_dp=0 during SHOW of digit 7 while the source is src1, so the active source is identifiable.
- Undefined:
  - The source follows i_sel.
  - o_dp=1 constantly, and no frame counter is built.

Decomposition:
- sevseg_pkg holds:
  - the state enum {LOAD, BLANK, SHOW};
  - NUM_DIGITS=8;
  - the 16-entry hex decode constant and decode function;
  - the blank pattern constants SEG_OFF=7'h7F and AN_OFF=8'hFF.
- One sub-module, sevseg_slot_timer: slot counter plus digit index. Outputs slot_cnt, digit_idx, slot_wrap and frame_wrap.

Test Plan (CLK_DIV=8, BLANK_CYCLES=2):
- Reset: hold i_rst 3 cycles → o_an=FF, o_seg=7F, o_dp=1; first o_frame_start one cycle after release.
- Basic scan: i_src1=32'h89ABCDEF, i_sel=0 → digit 0 shows o_an=FE with o_seg=0111000 (F) for 6 cycles after 2 blank cycles. The order FE,FD,…,7F carries nibbles F,E,D,C,B,A,9,8. Frame length is 64 cycles.
- Select change: i_src0=32'h00000001 and toggle i_sel to 1 during digit 3 → display unchanged until the next o_frame_start, then o_cur_src=0 and digit 0 shows 1001111.
- Leading zeros: snapshot 32'h00000105, i_lz_blank=1 → digits 3..7 o_seg=7F with anodes still cycling; digit 1 shows 0 (0000001).
- Freeze: i_freeze=1, then change i_src0 from 32'h11111111 to 32'h22222222 → the next two frames still show 1s; the first frame after release shows 2s.
- Autocycle (macro defined, AUTO_FRAMES=2): o_cur_src toggles every 2 frames; o_dp=0 only during SHOW of digit 7 while o_cur_src=1.
